// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - shared word format and scheduler state encodings for mixer_arb
package mixer_pkg;
  localparam int WORD_W   = 9;
  localparam int FLAG_BIT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational priority-class then round-robin selector
module rr_pick #(
  parameter int N  = 6,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  prio,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx
);
  logic [N-1:0] cand;
  int           pos;

  always_comb begin
    cand   = (|(req & prio)) ? (req & prio) : req;
    winner = '0;
    idx    = '0;
    pos    = 0;
    // Walk from the farthest slot back toward ptr so the nearest requester wins last.
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (cand[IW'(pos)]) begin
        winner = N'(1) << pos;
        idx    = IW'(pos);
      end
    end
  end
endmodule

// File: rtl/mixer_arb.sv
// rtl/mixer_arb.sv - frame-granular scheduler sharing one output FIFO write port among input FIFOs
module mixer_arb
  import mixer_pkg::*;
#(
  parameter int NUM_PORTS     = 6,
  parameter int STALL_TIMEOUT = 1024,
  parameter int TMO_W         = 11
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [WORD_W*NUM_PORTS-1:0]   port_dout,
  input  logic [NUM_PORTS-1:0]          port_empty,
  output logic [NUM_PORTS-1:0]          port_rd_en,
  input  logic [NUM_PORTS-1:0]          prio_en,
  output logic [WORD_W-1:0]             din,
  input  logic                          full,
  output logic                          wr_en,
  output logic [NUM_PORTS-1:0]          grant,
  output logic                          stall_err
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_t               state, nstate;
  logic [IW-1:0]        gidx, rr_ptr, next_ptr, pick_idx;
  logic [NUM_PORTS-1:0] req, pick_oh;
  logic [WORD_W-1:0]    dout_arr [NUM_PORTS];
  logic [WORD_W-1:0]    word;
  logic [TMO_W-1:0]     wdog;
  logic                 seen_data, rd_d1;
  logic                 term_now, timeout, rd_any, wd_count;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_split
    assign dout_arr[i] = port_dout[WORD_W*i +: WORD_W];
  end

  assign req      = ~port_empty;
  assign next_ptr = (gidx == IW'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;

  rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick (
    .req    (req),
    .prio   (prio_en),
    .ptr    (rr_ptr),
    .winner (pick_oh),
    .idx    (pick_idx)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state <= IDLE;
    else          state <= nstate;
  end

  // Reads stop in the same cycle the terminator comes back, so no word of the next frame is taken.
  always_comb begin
    nstate   = state;
    word     = dout_arr[gidx];
    term_now = 1'b0;
    timeout  = 1'b0;
    rd_any   = 1'b0;
    wd_count = 1'b0;
    case (state)
      IDLE:  if (|req) nstate = XFER;
      XFER: begin
        term_now = rd_d1 & ~word[FLAG_BIT] & seen_data;
        wd_count = seen_data & port_empty[gidx];
        timeout  = wd_count & ~term_now & (wdog == TMO_W'(STALL_TIMEOUT - 1));
        rd_any   = ~port_empty[gidx] & ~full & ~term_now;
        if (term_now || timeout) nstate = DRAIN;
      end
      DRAIN: if (!rd_d1) nstate = IDLE;
      default: nstate = IDLE;
    endcase
    port_rd_en = rd_any ? grant : '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      grant     <= '0;
      gidx      <= '0;
      rr_ptr    <= '0;
      seen_data <= 1'b0;
      rd_d1     <= 1'b0;
      wdog      <= '0;
      din       <= '0;
      wr_en     <= 1'b0;
      stall_err <= 1'b0;
    end else begin
      rd_d1     <= rd_any;
      wr_en     <= rd_d1;
      stall_err <= timeout;
      if (rd_d1) din <= word;
      if (rd_any || state != XFER) wdog <= '0;
      else if (wd_count)           wdog <= wdog + 1'b1;
      case (state)
        IDLE:  if (|req) begin
          grant <= pick_oh;
          gidx  <= pick_idx;
        end
        XFER:  if (rd_d1 && word[FLAG_BIT]) seen_data <= 1'b1;
        DRAIN: if (!rd_d1) begin
          grant     <= '0;
          seen_data <= 1'b0;
          rr_ptr    <= next_ptr;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mixer_arb.sv
// tb/tb_mixer_arb.sv - scoreboard bench for mixer_arb with modelled input FIFOs
module tb_mixer_arb;
  localparam int NP = 6;
  localparam int W = 9;
  localparam int DEPTH = 64;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [W*NP-1:0] port_dout;
  logic [NP-1:0] port_empty, port_rd_en, grant;
  logic [NP-1:0] prio_en = '0;
  logic [W-1:0]  din;
  logic          full = 1'b0;
  logic          wr_en, stall_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit sb_off = 1'b0;

  typedef struct { logic [8:0] w; int port; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  logic [W-1:0] mem [NP][DEPTH];
  int push_cnt [NP];
  logic [NP-1:0] rd_h1 = '0, rd_h2 = '0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  mixer_arb #(.NUM_PORTS(NP), .STALL_TIMEOUT(16), .TMO_W(5)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .port_dout  (port_dout),
    .port_empty (port_empty),
    .port_rd_en (port_rd_en),
    .prio_en    (prio_en),
    .din        (din),
    .full       (full),
    .wr_en      (wr_en),
    .grant      (grant),
    .stall_err  (stall_err)
  );

  for (genvar i = 0; i < NP; i++) begin : g_fifo
    int pop_cnt = 0;
    logic [W-1:0] dout_r = '0;
    assign port_empty[i] = (push_cnt[i] == pop_cnt);
    assign port_dout[W*i +: W] = dout_r;
    always @(posedge sys_clk)
      if (port_rd_en[i] && !port_empty[i]) begin
        dout_r  <= mem[i][pop_cnt % DEPTH];
        pop_cnt <= pop_cnt + 1;
      end
  end

  always @(negedge sys_clk) begin
    if (!sys_rst || sb_off) begin
      rd_h1 = '0;
      rd_h2 = '0;
    end else begin
      if (wr_en || (|rd_h2)) begin
        total++;
        if (wr_en !== (|rd_h2)) begin
          bad++;
          $display("FAIL wr_latency: wr_en=%b, read two cycles earlier=%b", wr_en, |rd_h2);
        end
      end
      if (|port_rd_en) begin
        total++;
        if (port_rd_en !== grant) begin
          bad++;
          $display("FAIL rd_onehot: port_rd_en=%b, required grant=%b", port_rd_en, grant);
        end
      end
      if (full) begin
        total++;
        if (port_rd_en !== '0) begin
          bad++;
          $display("FAIL rd_while_full: port_rd_en=%b, required 0", port_rd_en);
        end
      end
      if (wr_en) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra: din=%h written, required no write", din);
        end else begin
          e = exp_q.pop_front();
          if (din !== e.w || grant !== (6'b1 << e.port)) begin
            bad++;
            $display("FAIL sb_word: din=%h grant=%b, required din=%h grant=%b", din, grant, e.w, 6'b1 << e.port);
          end
        end
      end
      rd_h2 = rd_h1;
      rd_h1 = port_rd_en;
    end
  end

  function automatic logic [8:0] fw(input int n, input int seed, input int k);
    logic [7:0] b;
    b = 8'(seed + k);
    return (k == n - 1) ? {1'b0, b} : {1'b1, b};
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_word(input int p, input logic [8:0] w);
    mem[p][push_cnt[p] % DEPTH] = w;
    push_cnt[p]++;
  endtask

  task automatic load_frame(input int p, input int n, input int seed);
    for (int k = 0; k < n; k++) push_word(p, fw(n, seed, k));
  endtask

  task automatic expect_frame(input int p, input int n, input int seed);
    for (int k = 0; k < n; k++) exp_q.push_back('{w: fw(n, seed, k), port: p});
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (exp_q.size() == 0 && grant == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_done(input string name, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %0d words still pending, grant=%b; required all written and grant=0", name, exp_q.size(), grant);
    end
  endtask

  task automatic test_reset();
    #2 sys_rst = 1'b0;
    #1;
    total++;
    if ({grant, port_rd_en, wr_en, stall_err, din} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: grant=%b rd_en=%b wr_en=%b stall_err=%b din=%h, required all 0",
               grant, port_rd_en, wr_en, stall_err, din);
    end
    repeat (2) step();
    sys_rst = 1'b1;
    step();
    total++;
    if (grant !== '0 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: grant=%b wr_en=%b, required 0", grant, wr_en);
    end
  endtask

  task automatic test_single();
    bit ok;
    step();
    push_word(2, 9'h1AA); push_word(2, 9'h1BB); push_word(2, 9'h000);
    exp_q.push_back('{w: 9'h1AA, port: 2});
    exp_q.push_back('{w: 9'h1BB, port: 2});
    exp_q.push_back('{w: 9'h000, port: 2});
    for (int i = 0; i < 10 && grant == '0; i++) @(negedge sys_clk);
    total++;
    if (grant !== 6'b000100) begin
      bad++;
      $display("FAIL single_grant: grant=%b, required 000100", grant);
    end
    wait_done(40, ok);
    check_done("single_done", ok);
    total++;
    if (dut.rr_ptr !== 3'd3) begin
      bad++;
      $display("FAIL single_ptr: rr_ptr=%0d, required 3", dut.rr_ptr);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    step();
    load_frame(0, 2, 8'h10);
    expect_frame(0, 2, 8'h10);
    wait_done(40, ok);
    check_done("rr_setup_done", ok);
    step();
    load_frame(0, 4, 8'h20);
    load_frame(3, 4, 8'h30);
    expect_frame(3, 4, 8'h30);
    expect_frame(0, 4, 8'h20);
    wait_done(80, ok);
    check_done("rr_done", ok);
    total++;
    if (dut.rr_ptr !== 3'd1) begin
      bad++;
      $display("FAIL rr_ptr: rr_ptr=%0d, required 1", dut.rr_ptr);
    end
  endtask

  task automatic test_priority();
    bit ok;
    step();
    prio_en = 6'b010000;
    load_frame(1, 3, 8'h40);
    load_frame(4, 5, 8'h50);
    expect_frame(4, 5, 8'h50);
    expect_frame(1, 3, 8'h40);
    wait_done(80, ok);
    check_done("prio_done", ok);
    prio_en = '0;
  endtask

  task automatic test_full();
    bit ok;
    int nw, nrd;
    step();
    push_word(0, 9'h055);
    exp_q.push_back('{w: 9'h055, port: 0});
    load_frame(0, 12, 8'h60);
    expect_frame(0, 12, 8'h60);
    nw = 0;
    for (int i = 0; i < 20 && nw < 3; i++) begin
      @(negedge sys_clk);
      if (wr_en) nw++;
    end
    step();
    full = 1'b1;
    nw = 0;
    nrd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      if (wr_en) nw++;
      if (|port_rd_en) nrd++;
    end
    total++;
    if (nw > 2 || nrd != 0) begin
      bad++;
      $display("FAIL full_hold: writes=%0d reads=%0d while full, required writes<=2 reads=0", nw, nrd);
    end
    step();
    full = 1'b0;
    wait_done(80, ok);
    check_done("full_done", ok);
  endtask

  task automatic test_stall();
    bit ok;
    int t_wr, t_st, n_st;
    step();
    push_word(5, 9'h101);
    exp_q.push_back('{w: 9'h101, port: 5});
    for (int i = 0; i < 10 && grant != 6'b100000; i++) @(negedge sys_clk);
    step();
    load_frame(1, 3, 8'h70);
    expect_frame(1, 3, 8'h70);
    t_wr = -1;
    t_st = -1;
    n_st = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (wr_en && din == 9'h101 && t_wr < 0) t_wr = cyc;
      if (stall_err) begin
        n_st++;
        if (t_st < 0) t_st = cyc;
      end
    end
    total++;
    if (n_st != 1 || t_wr < 0 || t_st - t_wr != 16) begin
      bad++;
      $display("FAIL stall_pulse: pulses=%0d gap=%0d, required pulses=1 gap=16", n_st, t_st - t_wr);
    end
    wait_done(40, ok);
    check_done("stall_done", ok);
  endtask

  task automatic test_async_reset();
    bit ok;
    step();
    sb_off = 1'b1;
    load_frame(4, 10, 8'h80);
    for (int i = 0; i < 10 && grant == '0; i++) @(negedge sys_clk);
    total++;
    if (grant !== 6'b010000) begin
      bad++;
      $display("FAIL areset_pre_grant: grant=%b, required 010000", grant);
    end
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk);
    #2 sys_rst = 1'b0;
    #1;
    total++;
    if (grant !== '0 || port_rd_en !== '0 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL areset_outputs: grant=%b rd_en=%b wr_en=%b, required all 0", grant, port_rd_en, wr_en);
    end
    push_cnt[4] = g_fifo[4].pop_cnt;
    repeat (2) step();
    sys_rst = 1'b1;
    sb_off = 1'b0;
    exp_q.delete();
    load_frame(1, 3, 8'h90);
    load_frame(4, 3, 8'hA0);
    expect_frame(1, 3, 8'h90);
    expect_frame(4, 3, 8'hA0);
    wait_done(80, ok);
    check_done("areset_done", ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_full();
    test_stall();
    test_async_reset();
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule

// File: doc/mixer_arb.md
Name: mixer_arb

Overview:
Frame-granular scheduler that shares one 9-bit output FIFO write port among NUM_PORTS input FIFOs. A granted port keeps the grant until its frame completes, so frames are never interleaved.
Selection is priority-then-round-robin, with a stall watchdog so a starved mid-frame port cannot hold the output forever. It sits between the per-port TX queues and the TX mixer queue, replacing fixed-order port sequencing.

Parameters:
NUM_PORTS, 6, number of requesting input FIFOs (2..8)
STALL_TIMEOUT, 1024, cycles a granted port may sit empty mid-frame before abort
TMO_W, 11, watchdog counter width (must satisfy 2^TMO_W > STALL_TIMEOUT)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset, asynchronous, active-low
port_dout  in  9*NUM_PORTS  FIFO read data; port i at [9i+8:9i]; bit 8 = frame-data flag
port_empty  in  NUM_PORTS  FIFO empty flags
port_rd_en  out  NUM_PORTS  FIFO read strobes, one-hot or zero
prio_en  in  NUM_PORTS  1 = port belongs to high-priority class (sampled only at arbitration)
din  out  9  output FIFO write data
full  in  1  output FIFO almost-full; must assert with at least 3 free entries
wr_en  out  1  output FIFO write strobe
grant  out  NUM_PORTS  one-hot current owner, 0 when idle
stall_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (sys_rst=0, async): all outputs 0; state IDLE; rr pointer = port 0; watchdog = 0; seen_data = 0.
- Read timing: FIFO dout is valid the cycle after rd_en. din/wr_en are registered, so wr_en follows rd_en by exactly 2 cycles. Every issued read is written, including across full and abort.
- Word format: bit8=1 is frame data. The first bit8=0 word after a bit8=1 word is the frame terminator; it is written and ends the frame. Leading bit8=0 words are passed through.
- States:
  - IDLE: req = ~port_empty. If any req, choose winner, set grant, go XFER.
  - XFER: port_rd_en[g] = ~port_empty[g] & ~full & ~term_issued.
    - On the returned word: if bit8=1, set seen_data. If bit8=0 and seen_data, mark term_seen.
    - Once a read is issued whose data turns out to be the terminator, no further reads are issued: the rd_en→data check happens the next cycle, so at most 1 extra read is possible. Any extra word is written, not dropped; accept it as idle filler.
    - term_seen → DRAIN.
  - DRAIN: wait until no read is in flight (≤2 cycles). Then clear grant, seen_data and term_seen, advance rr pointer to g+1 mod NUM_PORTS, and go IDLE.
- Arbitration: if any req&prio_en, pick among those; else pick among all req. Within a class, round-robin starting at the rr pointer. The pointer is shared across classes.
- Watchdog: counts while in XFER, seen_data=1 and port_empty[g]=1. It clears on any read of g.
  - At STALL_TIMEOUT: pulse stall_err, go DRAIN. No synthetic terminator is inserted.
  - The watchdog does not run before seen_data, so an empty port before its first data word is not timed out.
- full: no new reads while full=1. In-flight words still write, up to 2.
- Simultaneous: a request arriving on another port during XFER waits; no preemption. prio_en changes mid-frame have no effect.
- NUM_PORTS=1: pointer stays 0.

Decomposition:
- Package mixer_pkg: WORD_W=9, FLAG_BIT=8, state encodings IDLE/XFER/DRAIN.
- One sub-module, rr_pick: combinational priority+round-robin selector. Inputs req, prio, ptr; outputs one-hot winner and index.

Test Plan:
1. Port 2 holds {0x1AA,0x1BB,0x000} (flag in bit8), other ports empty → grant=0b000100; din sequence 0x1AA,0x1BB,0x000 with wr_en 2 cycles after each rd_en; grant=0 afterwards; rr pointer=3.
2. Ports 0 and 3 each hold a 4-word frame, prio_en=0, pointer=1 → port 3 frame written fully, then port 0; no interleaving.
3. Ports 1 and 4 hold frames, prio_en=0b010000 → port 4 served first regardless of pointer.
4. Hold full=1 for 10 cycles during port 0 XFER → at most 2 wr_en after full rises, zero rd_en while full; stream resumes intact.
5. Port 5 writes 0x101, then starves; STALL_TIMEOUT=16 → stall_err pulses after 16 empty cycles; grant releases; next pending port is granted.
6. Assert sys_rst low mid-frame asynchronously → port_rd_en, wr_en and grant go 0 without a clock edge; after release, the first arbitration starts from port 0.
